// File: rtl/rps_feature_stream_if.sv
// Pixel stream and feature record bundle between the pixel source, the
// rps_feature_stream front end and the downstream classifier stage.
interface rps_feature_stream_if #(
    parameter int WIDTH  = 64,
    parameter int LENGTH = 48,
    parameter int PIX_W  = 8
);
    localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic                 pix_valid;
    logic                 pix_ready;
    logic [3*PIX_W-1:0]   pix_data;
    logic                 pix_last;
    logic                 feat_valid;
    logic                 feat_ready;
    logic [31:0]          sum;
    logic [31:0]          sum_left;
    logic                 col_found;
    logic [COL_W-1:0]     leftmost_col;
    logic [LENGTH-1:0]    strip;
    logic                 frame_err;

    modport master (
        output pix_valid, pix_data, pix_last, feat_ready,
        input  pix_ready, feat_valid, sum, sum_left, col_found,
               leftmost_col, strip, frame_err
    );

    modport slave (
        input  pix_valid, pix_data, pix_last, feat_ready,
        output pix_ready, feat_valid, sum, sum_left, col_found,
               leftmost_col, strip, frame_err
    );
endinterface

// File: rtl/rps_feature_stream.sv
// Green-mask front end: builds a thresholded mask per frame, accumulates hit
// statistics, extracts one vertical strip and hands a feature record downstream.
module rps_feature_stream #(
    parameter int WIDTH        = 64,
    parameter int LENGTH       = 48,
    parameter int LEFT         = 32,
    parameter int PIX_W        = 8,
    parameter int STRIP_OFFSET = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [3*PIX_W-1:0]  lo_thresh,
    input  logic [3*PIX_W-1:0]  hi_thresh,
    rps_feature_stream_if.slave bus
);
    localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int ROW_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam int CNT_W = $clog2(LENGTH + 1);

    typedef enum logic [1:0] {ACCEPT, SCAN, OUT} state_e;

    state_e                         state_q;
    logic [LENGTH-1:0][WIDTH-1:0]   mask_q;
    logic [ROW_W-1:0]               row_q;
    logic [COL_W-1:0]               col_q;
    logic [3*PIX_W-1:0]             thr_lo_q;
    logic [3*PIX_W-1:0]             thr_hi_q;
    logic [31:0]                    sum_q;
    logic [31:0]                    sum_left_q;
    logic                           found_q;
    logic [COL_W-1:0]               leftmost_q;
    logic                           err_q;
    logic [CNT_W-1:0]               scan_cnt_q;
    logic [COL_W-1:0]               strip_col_q;
    logic [LENGTH-1:0]              strip_work_q;

    logic                           feat_valid_q;
    logic [31:0]                    sum_o_q;
    logic [31:0]                    sum_left_o_q;
    logic                           found_o_q;
    logic [COL_W-1:0]               leftmost_o_q;
    logic [LENGTH-1:0]              strip_o_q;
    logic                           err_o_q;

    logic                           xfer;
    logic                           first_pix;
    logic [3*PIX_W-1:0]             lo_sel;
    logic [3*PIX_W-1:0]             hi_sel;
    logic                           hit;
    logic                           in_left;
    logic                           last_idx;
    logic                           eof;
    logic [31:0]                    strip_sum;
    logic [COL_W-1:0]               strip_col_d;
    logic [ROW_W-1:0]               scan_row;
    logic [LENGTH-1:0]              strip_d;

    assign bus.pix_ready    = rst_n && (state_q == ACCEPT);
    assign bus.feat_valid   = feat_valid_q;
    assign bus.sum          = sum_o_q;
    assign bus.sum_left     = sum_left_o_q;
    assign bus.col_found    = found_o_q;
    assign bus.leftmost_col = leftmost_o_q;
    assign bus.strip        = strip_o_q;
    assign bus.frame_err    = err_o_q;

    // The first pixel of a frame classifies against the live thresholds;
    // every later pixel uses the copy latched on that first transfer.
    always_comb begin
        xfer      = bus.pix_valid && bus.pix_ready;
        first_pix = (row_q == '0) && (col_q == '0);
        lo_sel    = first_pix ? lo_thresh : thr_lo_q;
        hi_sel    = first_pix ? hi_thresh : thr_hi_q;
        hit       = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if ((bus.pix_data[i*PIX_W +: PIX_W] < lo_sel[i*PIX_W +: PIX_W]) ||
                (bus.pix_data[i*PIX_W +: PIX_W] > hi_sel[i*PIX_W +: PIX_W])) begin
                hit = 1'b0;
            end
        end
        in_left   = 32'(col_q) < 32'(LEFT);
        last_idx  = (row_q == ROW_W'(LENGTH - 1)) && (col_q == COL_W'(WIDTH - 1));
        eof       = last_idx || bus.pix_last;

        strip_sum = 32'(leftmost_q) + 32'(STRIP_OFFSET);
        if (!found_q) begin
            strip_col_d = '0;
        end else if (strip_sum > 32'(WIDTH - 1)) begin
            strip_col_d = COL_W'(WIDTH - 1);
        end else begin
            strip_col_d = strip_sum[COL_W-1:0];
        end

        // Scan count 0 is the column-select cycle; counts 1..LENGTH map to rows.
        scan_row           = ROW_W'(scan_cnt_q - CNT_W'(1));
        strip_d            = strip_work_q;
        strip_d[scan_row]  = found_q & mask_q[scan_row][strip_col_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ACCEPT;
            mask_q       <= '0;
            row_q        <= '0;
            col_q        <= '0;
            thr_lo_q     <= '0;
            thr_hi_q     <= '0;
            sum_q        <= '0;
            sum_left_q   <= '0;
            found_q      <= 1'b0;
            leftmost_q   <= '0;
            err_q        <= 1'b0;
            scan_cnt_q   <= '0;
            strip_col_q  <= '0;
            strip_work_q <= '0;
            feat_valid_q <= 1'b0;
            sum_o_q      <= '0;
            sum_left_o_q <= '0;
            found_o_q    <= 1'b0;
            leftmost_o_q <= '0;
            strip_o_q    <= '0;
            err_o_q      <= 1'b0;
        end else begin
            case (state_q)
                ACCEPT: begin
                    if (xfer) begin
                        if (first_pix) begin
                            thr_lo_q <= lo_thresh;
                            thr_hi_q <= hi_thresh;
                        end
                        mask_q[row_q][col_q] <= hit;
                        if (hit) begin
                            sum_q <= sum_q + 32'd1;
                        end
                        if (hit && in_left) begin
                            sum_left_q <= sum_left_q + 32'd1;
                        end
                        if (hit && (!found_q || (col_q < leftmost_q))) begin
                            leftmost_q <= col_q;
                            found_q    <= 1'b1;
                        end
                        if (eof) begin
                            err_q      <= bus.pix_last != last_idx;
                            scan_cnt_q <= '0;
                            state_q    <= SCAN;
                        end else if (col_q == COL_W'(WIDTH - 1)) begin
                            col_q <= '0;
                            row_q <= row_q + ROW_W'(1);
                        end else begin
                            col_q <= col_q + COL_W'(1);
                        end
                    end
                end
                SCAN: begin
                    scan_cnt_q <= scan_cnt_q + CNT_W'(1);
                    if (scan_cnt_q == '0) begin
                        strip_col_q  <= strip_col_d;
                        strip_work_q <= '0;
                    end else begin
                        strip_work_q <= strip_d;
                    end
                    // Publish the record together with the final strip row.
                    if (scan_cnt_q == CNT_W'(LENGTH)) begin
                        sum_o_q      <= sum_q;
                        sum_left_o_q <= sum_left_q;
                        found_o_q    <= found_q;
                        leftmost_o_q <= leftmost_q;
                        strip_o_q    <= strip_d;
                        err_o_q      <= err_q;
                        feat_valid_q <= 1'b1;
                        state_q      <= OUT;
                    end
                end
                OUT: begin
                    if (bus.feat_ready) begin
                        mask_q       <= '0;
                        row_q        <= '0;
                        col_q        <= '0;
                        sum_q        <= '0;
                        sum_left_q   <= '0;
                        found_q      <= 1'b0;
                        leftmost_q   <= '0;
                        err_q        <= 1'b0;
                        feat_valid_q <= 1'b0;
                        state_q      <= ACCEPT;
                    end
                end
                default: state_q <= ACCEPT;
            endcase
        end
    end
endmodule

// File: tb/tb_rps_feature_stream.sv
// Randomised self-checking bench for rps_feature_stream against a frame-level
// reference model of the green mask, strip and feature record.
module tb_rps_feature_stream;
    localparam int WIDTH  = 8;
    localparam int LENGTH = 4;
    localparam int LEFT   = 3;
    localparam int PIX_W  = 8;
    localparam int OFFS   = 1;
    localparam int NPIX   = WIDTH * LENGTH;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] loDrv;
    logic [23:0] hiDrv;

    rps_feature_stream_if #(.WIDTH(WIDTH), .LENGTH(LENGTH), .PIX_W(PIX_W)) bus ();

    rps_feature_stream #(
        .WIDTH(WIDTH), .LENGTH(LENGTH), .LEFT(LEFT), .PIX_W(PIX_W), .STRIP_OFFSET(OFFS)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .lo_thresh(loDrv),
        .hi_thresh(hiDrv),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int errCount = 0;
    int checkCount = 0;

    logic [23:0]       pixMem [NPIX];
    logic [23:0]       frameLo;
    logic [23:0]       frameHi;
    int                expSum;
    int                expLeft;
    bit                expFound;
    int                expLm;
    logic [LENGTH-1:0] expStrip;
    bit                expErr;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic bit isHit(input logic [23:0] p, input logic [23:0] lo, input logic [23:0] hi);
        for (int c = 0; c < 3; c++) begin
            if (p[c*8 +: 8] < lo[c*8 +: 8] || p[c*8 +: 8] > hi[c*8 +: 8]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Frame-level model: only the first n pixels ever reach the mask.
    task automatic computeExpected(input int n, input bit withLast);
        int sc;
        int idx;
        expSum = 0; expLeft = 0; expFound = 0; expLm = 0; expStrip = '0;
        for (int i = 0; i < n; i++) begin
            if (isHit(pixMem[i], frameLo, frameHi)) begin
                expSum++;
                if ((i % WIDTH) < LEFT) expLeft++;
                if (!expFound || (i % WIDTH) < expLm) expLm = i % WIDTH;
                expFound = 1;
            end
        end
        sc = expFound ? ((expLm + OFFS > WIDTH - 1) ? WIDTH - 1 : expLm + OFFS) : 0;
        for (int r = 0; r < LENGTH; r++) begin
            idx = r * WIDTH + sc;
            expStrip[r] = expFound && (idx < n) && isHit(pixMem[idx], frameLo, frameHi);
        end
        expErr = withLast ? (n != NPIX) : 1'b1;
    endtask

    task automatic checkRecord(input string tag);
        checkOutput({tag, ".sum"}, bus.sum, expSum);
        checkOutput({tag, ".sum_left"}, bus.sum_left, expLeft);
        checkOutput({tag, ".col_found"}, bus.col_found, expFound);
        checkOutput({tag, ".leftmost"}, bus.leftmost_col, expLm);
        checkOutput({tag, ".strip"}, bus.strip, expStrip);
        checkOutput({tag, ".frame_err"}, bus.frame_err, expErr);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".pix_ready"}, bus.pix_ready, 0);
        checkOutput({tag, ".feat_valid"}, bus.feat_valid, 0);
        checkOutput({tag, ".record"},
                    {bus.sum, bus.sum_left[15:0], bus.col_found, bus.leftmost_col, bus.strip, bus.frame_err}, 0);
    endtask

    // Streams one frame with random valid gaps, then checks latency, record,
    // back-pressure hold and the release handshake.
    task automatic applyStimulus(input string tag, input int n, input bit withLast,
                                 input int holdCycles, input bit scrambleThr);
        int  idx = 0;
        int  guard = 0;
        int  lat = 0;
        bit  acc;
        loDrv = frameLo;
        hiDrv = frameHi;
        computeExpected(n, withLast);
        while (idx < n && guard < 2000) begin
            bus.pix_valid = ($urandom_range(3) != 0);
            bus.pix_data  = pixMem[idx];
            bus.pix_last  = withLast && (idx == n - 1);
            acc = bus.pix_valid && bus.pix_ready;
            @(posedge clk); #1;
            guard++;
            if (acc) begin
                idx++;
                if (scrambleThr) begin
                    loDrv = 24'($urandom);
                    hiDrv = 24'($urandom);
                end
            end
        end
        bus.pix_valid = 1'b0;
        bus.pix_last  = 1'b0;
        checkOutput({tag, ".sent"}, idx, n);
        while (!bus.feat_valid && lat < 100) begin
            checkOutput({tag, ".busy_ready"}, bus.pix_ready, 0);
            @(posedge clk); #1;
            lat++;
        end
        checkOutput({tag, ".latency"}, lat, LENGTH + 1);
        checkRecord(tag);
        if (holdCycles > 0) begin
            repeat (holdCycles) @(posedge clk);
            #1;
            checkOutput({tag, ".hold_valid"}, bus.feat_valid, 1);
            checkOutput({tag, ".hold_ready"}, bus.pix_ready, 0);
            checkRecord({tag, ".hold"});
        end
        bus.feat_ready = 1'b1;
        @(posedge clk); #1;
        bus.feat_ready = 1'b0;
        checkOutput({tag, ".drop_valid"}, bus.feat_valid, 0);
        checkOutput({tag, ".rise_ready"}, bus.pix_ready, 1);
        checkOutput({tag, ".kept_sum"}, bus.sum, expSum);
        loDrv = frameLo;
        hiDrv = frameHi;
    endtask

    task automatic fillAll(input logic [23:0] v);
        for (int i = 0; i < NPIX; i++) pixMem[i] = v;
    endtask

    task automatic fillColumn(input int col, input logic [23:0] v);
        for (int i = 0; i < NPIX; i++) pixMem[i] = ((i % WIDTH) == col) ? v : 24'h0;
    endtask

    task automatic fillRandom();
        logic [7:0] lo, hi;
        for (int c = 0; c < 3; c++) begin
            lo = 8'($urandom_range(0, 128));
            hi = 8'(lo + 8'($urandom_range(0, 127)));
            frameLo[c*8 +: 8] = lo;
            frameHi[c*8 +: 8] = hi;
        end
        for (int i = 0; i < NPIX; i++) begin
            for (int c = 0; c < 3; c++) begin
                pixMem[i][c*8 +: 8] = ($urandom_range(3) == 0) ? 8'($urandom) :
                    8'($urandom_range(frameLo[c*8 +: 8], frameHi[c*8 +: 8]));
            end
        end
    endtask

    initial begin
        bus.pix_valid  = 1'b0;
        bus.pix_data   = '0;
        bus.pix_last   = 1'b0;
        bus.feat_ready = 1'b0;
        frameLo = 24'h00_80_00;
        frameHi = 24'h40_FF_40;
        loDrv = frameLo;
        hiDrv = frameHi;

        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset");
        rst_n = 1'b1;
        #1;
        checkOutput("release.pix_ready", bus.pix_ready, 1);
        @(posedge clk); #1;

        fillAll(24'h00_FF_00);
        applyStimulus("s1_full", NPIX, 1, 0, 0);

        fillColumn(5, 24'h00_FF_00);
        applyStimulus("s2_col5", NPIX, 1, 0, 0);
        fillColumn(7, 24'h00_FF_00);
        applyStimulus("s2_col7", NPIX, 1, 0, 0);

        fillAll(24'h0);
        pixMem[0] = 24'h40_80_40;
        pixMem[1] = 24'h41_80_40;
        pixMem[2] = 24'h40_7F_40;
        applyStimulus("s3_bounds", NPIX, 1, 0, 1);

        fillAll(24'h0);
        applyStimulus("s4_nohit", NPIX, 1, 0, 0);

        fillRandom();
        applyStimulus("s5_hold", NPIX, 1, 10, 0);
        fillRandom();
        applyStimulus("s5_next", NPIX, 1, 0, 0);

        frameLo = 24'h00_80_00;
        frameHi = 24'h40_FF_40;
        fillAll(24'h00_FF_00);
        applyStimulus("s6_early", 20, 1, 0, 0);
        applyStimulus("s6_nolast", NPIX, 0, 0, 0);

        for (int i = 0; i < 10; i++) begin
            bus.pix_valid = 1'b1;
            bus.pix_data  = 24'h00_FF_00;
            @(posedge clk); #1;
        end
        bus.pix_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        checkAllZero("midreset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        applyStimulus("s6_after_reset", NPIX, 1, 0, 0);

        for (int k = 0; k < 8; k++) begin
            int n;
            fillRandom();
            n = ($urandom_range(3) == 0) ? int'($urandom_range(1, NPIX)) : NPIX;
            applyStimulus($sformatf("rand%0d", k), n, 1, int'($urandom_range(0, 3)), bit'($urandom_range(1)));
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end
endmodule

// File: doc/rps_feature_stream.md
Name: rps_feature_stream

Overview:
- Streaming, parametrised successor to the rock-paper-scissors green-mask classifier front end.
- Accepts one RGB pixel per handshake in raster order and builds a binary green mask using runtime-programmable inclusive thresholds.
- Accumulates the total and left-region counts and tracks the leftmost column containing a mask hit.
- After the frame, scans the mask over several cycles to extract one vertical strip, then presents the feature record to the downstream classifier stage through a valid/ready handshake.

Parameters:
- WIDTH, 64: columns per frame.
- LENGTH, 48: rows per frame.
- LEFT, 32: columns 0..LEFT-1 form the left region; must satisfy 1 <= LEFT <= WIDTH.
- PIX_W, 8: bits per colour channel.
- STRIP_OFFSET, 0: strip column = leftmost column + STRIP_OFFSET, clamped to WIDTH-1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- pix_valid  in  1  pixel present.
- pix_ready  out  1  block accepts a pixel.
- pix_data  in  3*PIX_W  channel0 in [PIX_W-1:0], channel1 next, channel2 in the MSBs.
- pix_last  in  1  final pixel of frame.
- lo_thresh  in  3*PIX_W  per-channel inclusive lower bound, same packing as pix_data.
- hi_thresh  in  3*PIX_W  per-channel inclusive upper bound.
- feat_valid  out  1  feature record valid.
- feat_ready  in  1  consumer accepts the record.
- sum  out  32  mask hits in the frame.
- sum_left  out  32  mask hits with column < LEFT.
- col_found  out  1  at least one hit in the frame.
- leftmost_col  out  $clog2(WIDTH)  smallest column with a hit.
- strip  out  LENGTH  strip[r] = mask[r][strip column].
- frame_err  out  1  pix_last was misplaced or missing.

Behaviour:
- Reset: all outputs are 0 and pix_ready is 0 while rst_n is low. On release, state is ACCEPT and pix_ready becomes 1. Mask, counters, row/col indices and flags are cleared. Reset mid-frame or mid-scan discards all work.
- States: ACCEPT → SCAN → OUT → ACCEPT.
- pix_ready = (state == ACCEPT). Transfer happens on pix_valid && pix_ready.
- Hit definition: each channel satisfies lo <= ch <= hi, unsigned and inclusive on both ends. Pixel index 0 uses the live threshold ports and latches them. All later pixels of the frame use the latched copy, so threshold changes mid-frame have no effect.
- Per transfer:
  - mask[row][col] <= hit.
  - sum += hit.
  - sum_left += hit && col < LEFT.
  - If hit and (no prior hit, or col < leftmost), leftmost <= col.
  - col increments and wraps to 0 at WIDTH-1, incrementing row.
- End of frame: the transfer that has pix_last set, or the transfer at index LENGTH*WIDTH-1, whichever comes first.
  - frame_err = 1 if pix_last arrives before the final index, or is absent at the final index.
  - Mask bits not written stay 0.
  - Next state is SCAN.
- SCAN:
  - Strip column = min(leftmost + STRIP_OFFSET, WIDTH-1), computed at SCAN entry; 0 if there were no hits.
  - One row per cycle, r = 0..LENGTH-1, writing strip[r].
  - If there were no hits, strip is forced to all zeros, but SCAN still runs exactly LENGTH cycles, so latency is fixed.
- OUT:
  - feat_valid = 1 with all record outputs stable.
  - Latency: feat_valid rises LENGTH+1 cycles after the end-of-frame transfer edge.
  - feat_valid holds until feat_valid && feat_ready.
  - On that handshake: clear mask, sum, sum_left, leftmost, col_found, frame_err and indices. feat_valid drops and pix_ready rises on the next cycle.
  - Record outputs keep their last value until the next OUT.
- No overlap: pixels are not accepted during SCAN or OUT.
- Arithmetic: counters are 32-bit, cannot overflow for WIDTH*LENGTH < 2^32, and are zero-extended.

Test Plan (WIDTH=8, LENGTH=4, LEFT=3, PIX_W=8, STRIP_OFFSET=1, lo=0x00_80_00, hi=0x40_FF_40):
1. All 32 pixels 0x00_FF_00, pix_last on the 32nd → sum=32, sum_left=12, col_found=1, leftmost_col=0, strip=4'b1111, frame_err=0, feat_valid exactly 5 cycles after the last transfer.
2. Hits only in column 5 → sum=4, sum_left=0, leftmost_col=5, strip=0000 (column 6). Repeat with hits only in column 7 → strip=1111 (clamped to column 7).
3. Pixel 0x40_80_40 (exact bounds) is a hit; 0x41_80_40 and 0x40_7F_40 are not → sum=1 for a frame containing one of each.
4. No hits → sum=0, col_found=0, leftmost_col=0, strip=0; latency still 5 cycles.
5. Hold feat_ready=0 for 10 cycles in OUT → feat_valid and outputs stable, pix_ready=0. Then pulse feat_ready → the next frame is accepted and its results are independent of the first.
6. pix_last on transfer 20 → frame_err=1, sum counts only 20 pixels. Separately, assert rst_n=0 after 10 pixels → all outputs 0, and a following clean frame reproduces scenario 1.
